// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared phase-state constants and transition classifier for the quadrature decoder
package quad_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_10 = 2'b10;

  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_UP      = 2'd1,
    TR_DOWN    = 2'd2,
    TR_ILLEGAL = 2'd3
  } tr_kind_e;

  // Successor of a phase state when rotating in the counting-up direction
  function automatic logic [1:0] next_up(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      ST_00:   n = ST_01;
      ST_01:   n = ST_11;
      ST_11:   n = ST_10;
      default: n = ST_00;
    endcase
    return n;
  endfunction

  function automatic tr_kind_e classify(input logic [1:0] prev, input logic [1:0] cur);
    tr_kind_e k;
    if (prev == cur)                k = TR_NONE;
    else if (cur == next_up(prev))  k = TR_UP;
    else if (prev == next_up(cur))  k = TR_DOWN;
    else                            k = TR_ILLEGAL;
    return k;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// rtl/quad_sync_filter.sv - single-channel synchronizer plus persistence filter for one encoder phase
module quad_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  input  logic i_primed,
  output logic o_filt,
  output logic o_pre
);

  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_cnt;
  logic                   r_filt;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  // Value about to enter the last sync stage; priming loads it so filt matches sync output
  assign o_pre  = r_sync[SYNC_STAGES-2];
  assign o_filt = r_filt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      if (!i_primed) begin
        r_filt <= r_sync[SYNC_STAGES-2];
        r_cnt  <= '0;
      end else if (w_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= w_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature A/B decoder producing step/dir pulses, wrapping position and sticky error
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enc_a,
  input  logic             i_enc_b,
  input  logic             i_clr,
  input  logic             i_err_clr,
  output logic             o_step,
  output logic             o_dir,
  output logic [CNT_W-1:0] o_pos,
  output logic             o_err
);

  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES - 1);

  logic             r_primed;
  logic [2:0]       r_prime_cnt;
  logic [1:0]       r_prev;
  logic             r_step;
  logic             r_dir;
  logic [CNT_W-1:0] r_pos;
  logic             r_err;

  logic             w_filt_a;
  logic             w_filt_b;
  logic             w_pre_a;
  logic             w_pre_b;
  logic [1:0]       w_cur;
  tr_kind_e         w_tr;

  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_in     (i_enc_a),
    .i_primed (r_primed),
    .o_filt   (w_filt_a),
    .o_pre    (w_pre_a)
  );

  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_in     (i_enc_b),
    .i_primed (r_primed),
    .o_filt   (w_filt_b),
    .o_pre    (w_pre_b)
  );

  assign w_cur = {w_filt_a, w_filt_b};

  always_comb begin
    w_tr = TR_NONE;
    if (r_primed) w_tr = classify(r_prev, w_cur);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_primed    <= 1'b0;
      r_prime_cnt <= '0;
      r_prev      <= ST_00;
      r_step      <= 1'b0;
      r_dir       <= 1'b0;
      r_pos       <= '0;
      r_err       <= 1'b0;
    end else begin
      // Until the sync chain holds a real sample, prev tracks what the filters load
      if (!r_primed) begin
        r_prev <= {w_pre_a, w_pre_b};
        if (r_prime_cnt == PRIME_LAST) r_primed <= 1'b1;
        else                           r_prime_cnt <= r_prime_cnt + 3'd1;
      end else begin
        r_prev <= w_cur;
      end

      r_step <= (w_tr == TR_UP) || (w_tr == TR_DOWN);

      if (w_tr == TR_UP)        r_dir <= 1'b1;
      else if (w_tr == TR_DOWN) r_dir <= 1'b0;

      if (i_clr)                r_pos <= '0;
      else if (w_tr == TR_UP)   r_pos <= r_pos + CNT_W'(1);
      else if (w_tr == TR_DOWN) r_pos <= r_pos - CNT_W'(1);

      if (w_tr == TR_ILLEGAL)   r_err <= 1'b1;
      else if (i_err_clr)       r_err <= 1'b0;
    end
  end

  assign o_step = r_step;
  assign o_dir  = r_dir;
  assign o_pos  = r_pos;
  assign o_err  = r_err;

endmodule
